matrix_operand_fetch: RTL and testbench

Parametrised operand loader between the matrix storage read port and the compute unit. On a start edge it fetches 1..MAX_OPS operand matrices by ID, one at a time, over the storage rd_en/rd_done handshake. Each result is latched into a per-slot register bank.
- Adds operand-count selection, a per-read timeout, abort, and error reporting.
- Replaces the fixed two-operand loader inside the matrix core top.

---
 rtl/matrix_core_pkg.sv | 27 ++
 rtl/rise_edge_detect.sv | 18 +
 rtl/matrix_operand_fetch.sv | 194 +++++++++++++++++++
 tb/tb_matrix_operand_fetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_core_pkg.sv
// Shared types and constants for the matrix core: error codes, operand-fetch FSM
// encoding and the flattened matrix data width.
package matrix_core_pkg;

    localparam int unsigned ERR_W = 3;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_CNT     = 3'd1;
    localparam logic [ERR_W-1:0] ERR_INVALID = 3'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd3;

    localparam int unsigned DEF_ELEM_W  = 8;
    localparam int unsigned DEF_MAX_DIM = 5;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FETCH_ISSUE = 2'd1,
        ST_FETCH_WAIT  = 2'd2,
        ST_DONE        = 2'd3
    } fetch_state_e;

    // Flattened matrix payload width: every element of a MAX_DIM x MAX_DIM matrix.
    function automatic int unsigned data_w(input int unsigned elem_w, input int unsigned max_dim);
        return elem_w * max_dim * max_dim;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: registers the level and emits a combinational one-cycle pulse.
module rise_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse_c
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign pulse_c = level & ~level_q;

endmodule

// File: rtl/matrix_operand_fetch.sv
// Operand loader: on a start edge fetches 1..MAX_OPS matrices by ID over the storage
// rd_en/rd_done handshake into per-slot registers, with timeout, abort and error codes.
module matrix_operand_fetch
    import matrix_core_pkg::*;
#(
    parameter int unsigned MAX_OPS = 3,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned DIM_W   = 4,
    parameter int unsigned ELEM_W  = DEF_ELEM_W,
    parameter int unsigned MAX_DIM = DEF_MAX_DIM,
    parameter int unsigned CNT_W   = $clog2(MAX_OPS + 1),
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned DATA_W = data_w(ELEM_W, MAX_DIM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            num_ops,
    input  logic [MAX_OPS*ID_W-1:0]     op_ids,
    output logic [ID_W-1:0]             rd_idx,
    output logic                        rd_en,
    input  logic                        rd_done,
    input  logic                        rd_valid,
    input  logic [DIM_W-1:0]            rd_m,
    input  logic [DIM_W-1:0]            rd_n,
    input  logic [DATA_W-1:0]           rd_data,
    output logic [MAX_OPS*DIM_W-1:0]    op_m_flat,
    output logic [MAX_OPS*DIM_W-1:0]    op_n_flat,
    output logic [MAX_OPS*DATA_W-1:0]   op_data_flat,
    output logic [MAX_OPS-1:0]          op_valid,
    output logic                        busy,
    output logic                        done,
    output logic [ERR_W-1:0]            err,
    output logic [CNT_W-1:0]            fetched
);

    localparam int unsigned IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    fetch_state_e       state, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]    rd_idx_d;
    logic               rd_en_d;
    logic               busy_d;
    logic               done_d;
    logic [ERR_W-1:0]   err_d;
    logic [CNT_W-1:0]   fetched_d;
    logic [MAX_OPS-1:0] op_valid_d;
    logic               load_slot;
    logic               start_pulse;

    logic [DIM_W-1:0]   slot_m    [MAX_OPS];
    logic [DIM_W-1:0]   slot_n    [MAX_OPS];
    logic [DATA_W-1:0]  slot_data [MAX_OPS];

    rise_edge_detect u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (start),
        .pulse_c (start_pulse)
    );

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_d    = state;
        k_d        = k_q;
        num_d      = num_q;
        timer_d    = timer_q;
        rd_idx_d   = rd_idx;
        err_d      = err;
        fetched_d  = fetched;
        op_valid_d = op_valid;
        load_slot  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_pulse) begin
                    op_valid_d = '0;
                    fetched_d  = '0;
                    err_d      = ERR_NONE;
                    k_d        = '0;
                    num_d      = num_ops;
                    if (num_ops == '0 || num_ops > CNT_W'(MAX_OPS)) begin
                        err_d   = ERR_CNT;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH_ISSUE;
                    end
                end
            end
            ST_FETCH_ISSUE: begin
                timer_d = '0;
                state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                // A response in the final timer cycle still counts as a good read.
                if (rd_done) begin
                    load_slot       = 1'b1;
                    op_valid_d[k_q] = rd_valid;
                    if (!rd_valid) begin
                        err_d   = ERR_INVALID;
                        state_d = ST_DONE;
                    end else begin
                        fetched_d = fetched + CNT_W'(1);
                        if (CNT_W'(k_q) == num_q - CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            k_d     = k_q + IDX_W'(1);
                            state_d = ST_FETCH_ISSUE;
                        end
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            op_valid_d = '0;
            fetched_d  = '0;
            err_d      = ERR_NONE;
            load_slot  = 1'b0;
        end

        // rd_en and rd_idx are presented during the single FETCH_ISSUE cycle.
        if (state_d == ST_FETCH_ISSUE) rd_idx_d = op_ids[k_d*ID_W +: ID_W];
        rd_en_d = (state_d == ST_FETCH_ISSUE);
        busy_d  = (state_d == ST_FETCH_ISSUE) || (state_d == ST_FETCH_WAIT);
        done_d  = (state == ST_DONE) && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k_q      <= '0;
            num_q    <= '0;
            timer_q  <= '0;
            rd_idx   <= '0;
            rd_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
            fetched  <= '0;
            op_valid <= '0;
        end else begin
            state    <= state_d;
            k_q      <= k_d;
            num_q    <= num_d;
            timer_q  <= timer_d;
            rd_idx   <= rd_idx_d;
            rd_en    <= rd_en_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            fetched  <= fetched_d;
            op_valid <= op_valid_d;
        end
    end

    // Slot bank: written only by a storage response while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_OPS); i++) begin
                slot_m[i]    <= '0;
                slot_n[i]    <= '0;
                slot_data[i] <= '0;
            end
        end else if (load_slot) begin
            slot_m[k_q]    <= rd_m;
            slot_n[k_q]    <= rd_n;
            slot_data[k_q] <= rd_data;
        end
    end

    for (genvar g = 0; g < int'(MAX_OPS); g++) begin : g_flat
        assign op_m_flat[g*DIM_W +: DIM_W]       = slot_m[g];
        assign op_n_flat[g*DIM_W +: DIM_W]       = slot_n[g];
        assign op_data_flat[g*DATA_W +: DATA_W]  = slot_data[g];
    end

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// Randomised bench for matrix_operand_fetch against a cycle-count reference model
// and a behavioural storage model with per-ID latency and validity.
module tb_matrix_operand_fetch;

    localparam int MO   = 3;
    localparam int IW   = 4;
    localparam int DW   = 4;
    localparam int DATW = 200;
    localparam int CW   = 3;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CW-1:0]     num_ops = '0;
    logic [MO*IW-1:0]  op_ids = '0;
    logic [IW-1:0]     rd_idx;
    logic              rd_en;
    logic              rd_done = 1'b0;
    logic              rd_valid = 1'b0;
    logic [DW-1:0]     rd_m = '0;
    logic [DW-1:0]     rd_n = '0;
    logic [DATW-1:0]   rd_data = '0;
    logic [MO*DW-1:0]  op_m_flat;
    logic [MO*DW-1:0]  op_n_flat;
    logic [MO*DATW-1:0] op_data_flat;
    logic [MO-1:0]     op_valid;
    logic              busy;
    logic              done;
    logic [2:0]        err;
    logic [CW-1:0]     fetched;

    int vectors = 0;
    int miscompares = 0;

    // storage contents, owned by the main initial block
    logic [DW-1:0]   mem_m [16];
    logic [DW-1:0]   mem_n [16];
    logic [DATW-1:0] mem_d [16];
    bit              mem_v [16];
    int              mem_lat [16];

    // monitor state, owned by the storage process
    int cyc = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int idx_log[$];

    matrix_operand_fetch #(
        .MAX_OPS(MO), .ID_W(IW), .DIM_W(DW), .ELEM_W(8), .MAX_DIM(5),
        .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_ops(num_ops), .op_ids(op_ids),
        .rd_idx(rd_idx), .rd_en(rd_en), .rd_done(rd_done), .rd_valid(rd_valid),
        .rd_m(rd_m), .rd_n(rd_n), .rd_data(rd_data),
        .op_m_flat(op_m_flat), .op_n_flat(op_n_flat), .op_data_flat(op_data_flat),
        .op_valid(op_valid), .busy(busy), .done(done), .err(err), .fetched(fetched)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Storage model and output monitor: a read issued in cycle c answers in cycle c+lat.
    initial begin : storage
        int cnt;
        int pidx;
        cnt = 0;
        pidx = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            rd_done = 1'b0;
            rd_valid = 1'b0;
            if (!rst_n) cnt = 0;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rd_done  = 1'b1;
                    rd_valid = mem_v[pidx];
                    rd_m     = mem_m[pidx];
                    rd_n     = mem_n[pidx];
                    rd_data  = mem_d[pidx];
                end
            end
            if (rd_en) begin
                en_cnt++;
                idx_log.push_back(int'(rd_idx));
                pidx = int'(rd_idx);
                cnt = mem_lat[pidx];
            end
        end
    end

    // Runs one fetch and checks it against the reference model.
    task automatic run_check(input int n, input int id0, input int id1, input int id2,
                             input int drain, input string name);
        int ids_a[3];
        int e_err, e_fet, e_off, e_reads, e_inv, t, lat, s, en0, d0, i0, w;
        bit [MO-1:0] e_valid;
        logic [DATW-1:0] pre_d [MO];
        logic [DW-1:0]   pre_m [MO];
        ids_a = '{id0, id1, id2};
        e_err = 0; e_fet = 0; e_off = 0; e_reads = 0; e_inv = -1; e_valid = '0;
        if (n == 0 || n > MO) begin
            e_err = 1;
            e_off = 2;
        end else begin
            t = 1;
            for (int k = 0; k < n; k++) begin
                e_reads++;
                lat = mem_lat[ids_a[k]];
                if (lat > TO) begin
                    e_err = 3;
                    e_off = t + TO + 2;
                    break;
                end
                if (!mem_v[ids_a[k]]) begin
                    e_err = 2;
                    e_inv = k;
                    e_off = t + lat + 2;
                    break;
                end
                e_valid[k] = 1'b1;
                e_fet++;
                if (k == n - 1) e_off = t + lat + 2;
                t = t + lat + 1;
            end
        end
        for (int k = 0; k < MO; k++) begin
            pre_d[k] = op_data_flat[k*DATW +: DATW];
            pre_m[k] = op_m_flat[k*DW +: DW];
        end

        @(negedge clk);
        num_ops = CW'(n);
        op_ids = {IW'(id2), IW'(id1), IW'(id0)};
        start = 1'b1;
        s = cyc; en0 = en_cnt; d0 = done_cnt; i0 = idx_log.size();
        w = 0;
        while (w < 200 && done_cnt == d0) begin
            @(negedge clk);
            w++;
        end
        start = 1'b0;
        vectors++;
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL %s done_wait: no done within 200 cycles", name);
        end else if (last_done_cyc - s != e_off) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, last_done_cyc - s, e_off);
        end
        repeat (drain) @(negedge clk);

        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - d0);
        end
        vectors++;
        if (en_cnt - en0 != e_reads) begin
            miscompares++;
            $display("FAIL %s rd_en_count: got %0d expected %0d", name, en_cnt - en0, e_reads);
        end
        for (int r = 0; r < e_reads; r++) begin
            if (i0 + r < idx_log.size()) begin
                vectors++;
                if (idx_log[i0 + r] != ids_a[r]) begin
                    miscompares++;
                    $display("FAIL %s rd_idx[%0d]: got %0d expected %0d", name, r, idx_log[i0 + r], ids_a[r]);
                end
            end
        end
        vectors++;
        if (err !== 3'(e_err)) begin
            miscompares++;
            $display("FAIL %s err: got %0d expected %0d", name, err, e_err);
        end
        vectors++;
        if (fetched !== CW'(e_fet)) begin
            miscompares++;
            $display("FAIL %s fetched: got %0d expected %0d", name, fetched, e_fet);
        end
        vectors++;
        if (op_valid !== e_valid) begin
            miscompares++;
            $display("FAIL %s op_valid: got %b expected %b", name, op_valid, e_valid);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after: got %b expected 0", name, busy);
        end
        for (int k = 0; k < MO; k++) begin
            logic [DATW-1:0] exp_d;
            logic [DW-1:0]   exp_m, exp_n;
            if (e_valid[k] || k == e_inv) begin
                exp_d = mem_d[ids_a[k]]; exp_m = mem_m[ids_a[k]]; exp_n = mem_n[ids_a[k]];
                vectors++;
                if (op_n_flat[k*DW +: DW] !== exp_n) begin
                    miscompares++;
                    $display("FAIL %s slot%0d_n: got %0d expected %0d", name, k, op_n_flat[k*DW +: DW], exp_n);
                end
            end else begin
                exp_d = pre_d[k]; exp_m = pre_m[k];
            end
            vectors++;
            if (op_data_flat[k*DATW +: DATW] !== exp_d || op_m_flat[k*DW +: DW] !== exp_m) begin
                miscompares++;
                $display("FAIL %s slot%0d_data: got m=%0d d=%h expected m=%0d d=%h", name, k,
                         op_m_flat[k*DW +: DW], op_data_flat[k*DATW +: DATW], exp_m, exp_d);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if (rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 3'd0 ||
            fetched !== '0 || op_valid !== '0 || rd_idx !== '0 || op_data_flat !== '0 ||
            op_m_flat !== '0 || op_n_flat !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b busy=%b done=%b err=%0d fetched=%0d valid=%b expected all 0",
                     rd_en, busy, done, err, fetched, op_valid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || en_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b rd_en_count=%0d expected 0", busy, done, en_cnt);
        end
    endtask

    task automatic test_two_ops;
        run_check(2, 3, 7, 0, 4, "two_ops");
    endtask

    task automatic test_invalid_operand;
        run_check(3, 3, 9, 7, 6, "invalid_op");
    endtask

    task automatic test_timeout;
        run_check(1, 12, 0, 0, 12, "timeout");
    endtask

    task automatic test_bad_count;
        run_check(0, 3, 7, 5, 3, "count_zero");
        for (int n = 4; n < 8; n++) run_check(n, 3, 7, 5, 3, "count_over");
    endtask

    task automatic test_abort;
        int s, en0, d0;
        logic [DATW-1:0] pre0;
        run_check(2, 3, 7, 0, 2, "pre_abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (op_valid !== '0 || fetched !== '0 || err !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_idle_clear: got valid=%b fetched=%0d err=%0d expected 0", op_valid, fetched, err);
        end
        pre0 = op_data_flat[0 +: DATW];
        @(negedge clk);
        num_ops = CW'(1);
        op_ids = {IW'(0), IW'(0), IW'(13)};
        start = 1'b1;
        s = cyc; en0 = en_cnt; d0 = done_cnt;
        while (cyc < s + 3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || op_valid !== '0) begin
            miscompares++;
            $display("FAIL abort_wait: got busy=%b valid=%b expected busy=0 valid=000", busy, op_valid);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || en_cnt - en0 != 1) begin
            miscompares++;
            $display("FAIL abort_after: got done_count=%0d rd_en_count=%0d expected 0 and 1", done_cnt - d0, en_cnt - en0);
        end
        vectors++;
        if (op_data_flat[0 +: DATW] !== pre0 || op_valid !== '0 || err !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_late_done: got valid=%b err=%0d slot0 changed=%b expected 000 0 0",
                     op_valid, err, op_data_flat[0 +: DATW] !== pre0);
        end
    endtask

    task automatic test_start_held;
        int en0, d0;
        @(negedge clk);
        num_ops = CW'(1);
        op_ids = {IW'(0), IW'(0), IW'(5)};
        start = 1'b1;
        en0 = en_cnt; d0 = done_cnt;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (en_cnt - en0 != 1 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL start_held: got rd_en=%0d done=%0d expected 1 and 1", en_cnt - en0, done_cnt - d0);
        end
        vectors++;
        if (fetched !== CW'(1) || op_valid !== 3'b001) begin
            miscompares++;
            $display("FAIL start_held_result: got fetched=%0d valid=%b expected 1 001", fetched, op_valid);
        end
    endtask

    task automatic test_toggle_busy;
        int s, en0, d0;
        @(negedge clk);
        num_ops = CW'(1);
        op_ids = {IW'(0), IW'(0), IW'(13)};
        start = 1'b1;
        s = cyc; en0 = en_cnt; d0 = done_cnt;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (en_cnt - en0 != 1 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL toggle_busy: got rd_en=%0d done=%0d expected 1 and 1", en_cnt - en0, done_cnt - d0);
        end
        vectors++;
        if (last_done_cyc - s != 1 + mem_lat[13] + 2) begin
            miscompares++;
            $display("FAIL toggle_latency: got %0d expected %0d", last_done_cyc - s, 1 + mem_lat[13] + 2);
        end
    endtask

    task automatic test_back_to_back;
        run_check(3, 5, 3, 7, 1, "b2b_a");
        run_check(2, 7, 5, 0, 1, "b2b_b");
        run_check(1, 3, 0, 0, 4, "b2b_c");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            run_check($urandom_range(1, MO), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), TO + 10, "random");
        end
    endtask

    task automatic test_reset_mid_fetch;
        int d0;
        @(negedge clk);
        num_ops = CW'(2);
        op_ids = {IW'(0), IW'(7), IW'(3)};
        start = 1'b1;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || op_valid !== '0 || fetched !== '0 || op_data_flat !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: got busy=%b en=%b valid=%b fetched=%0d expected all 0",
                     busy, rd_en, op_valid, fetched);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: got done_count=%0d busy=%b expected 0 0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = DW'($urandom_range(1, 5));
            mem_n[i] = DW'($urandom_range(1, 5));
            for (int b = 0; b < DATW; b += 8) mem_d[i][b +: 8] = 8'($urandom);
            mem_v[i] = ($urandom_range(0, 5) != 0);
            mem_lat[i] = $urandom_range(1, 4);
        end
        mem_v[3] = 1'b1;  mem_lat[3] = 2;
        mem_v[7] = 1'b1;  mem_lat[7] = 2;
        mem_v[5] = 1'b1;  mem_lat[5] = 1;
        mem_v[9] = 1'b0;  mem_lat[9] = 2;
        mem_v[12] = 1'b1; mem_lat[12] = TO + 5;
        mem_v[13] = 1'b1; mem_lat[13] = 8;

        test_reset();
        test_two_ops();
        test_invalid_operand();
        test_timeout();
        test_bad_count();
        test_abort();
        test_start_held();
        test_toggle_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
